// File: rtl/oled_pixel_streamer_pkg.sv
// Shared definitions for the OLED screen path: panel geometry defaults,
// SSD1331 address-window opcodes, the RGB565 palette used by the
// Game_Screen_N modules, and the streamer FSM state type.
package oled_pixel_streamer_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;

    // SSD1331 address-window opcodes (each takes a start and an end operand)
    localparam logic [7:0] SSD1331_SET_COL = 8'h15;
    localparam logic [7:0] SSD1331_SET_ROW = 8'h75;

    // RGB565 palette shared by the screen modules
    localparam logic [15:0] COL_BLACK  = 16'h0000;
    localparam logic [15:0] COL_WHITE  = 16'hFFFF;
    localparam logic [15:0] COL_RED    = 16'hF800;
    localparam logic [15:0] COL_GREEN  = 16'h07E0;
    localparam logic [15:0] COL_BLUE   = 16'h001F;
    localparam logic [15:0] COL_YELLOW = 16'hFFE0;

    typedef enum logic [1:0] {IDLE, CMD, PIX, GAP} strm_state_e;

    // Byte idx (0..5) of the full-panel address-window burst
    function automatic logic [7:0] win_cmd_byte(input logic [2:0] idx,
                                                input int w, input int h);
        case (idx)
            3'd0:    return SSD1331_SET_COL;
            3'd1:    return 8'h00;
            3'd2:    return 8'(w - 1);
            3'd3:    return SSD1331_SET_ROW;
            3'd4:    return 8'h00;
            default: return 8'(h - 1);
        endcase
    endfunction

endpackage

// File: rtl/oled_pixel_streamer_spi_byte_tx.sv
// SPI byte serialiser (mode 3, MSB first).
// A load strobe sampled on a clk edge starts the byte on that same edge:
// sclk drops and sdin shows the MSB. Each bit is sclk low for CLK_DIV clk,
// then high for CLK_DIV clk. done is high during the final clk of the last
// bit, so a load in that cycle continues with no gap between bytes.
// Ports: clk, rst_n; load/data/dc_in (byte request); sclk, sdin, d_cn (line
// outputs, idle 1/0/1); done (last-bit pulse).
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       dc_in,
    output logic       sclk,
    output logic       sdin,
    output logic       d_cn,
    output logic       done
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [6:0]    sh;      // bits still to send after the one on sdin
    logic [2:0]    bitcnt;
    logic [DW-1:0] divcnt;
    logic          active;
    logic          div_end;

    assign div_end = (divcnt == DW'(CLK_DIV - 1));
    assign done    = active && sclk && div_end && (bitcnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            bitcnt <= '0;
            divcnt <= '0;
            active <= 1'b0;
            sclk   <= 1'b1;
            sdin   <= 1'b0;
            d_cn   <= 1'b1;
        end else if (load) begin
            sh     <= data[6:0];
            bitcnt <= '0;
            divcnt <= '0;
            active <= 1'b1;
            sclk   <= 1'b0;
            sdin   <= data[7];
            d_cn   <= dc_in;
        end else if (active) begin
            if (div_end) begin
                divcnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else if (bitcnt == 3'd7) begin
                    // no follow-on byte: return the lines to idle
                    active <= 1'b0;
                    sdin   <= 1'b0;
                    d_cn   <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + 3'd1;
                    sclk   <= 1'b0;
                    sdin   <= sh[6];
                    sh     <= {sh[5:0], 1'b0};
                end
            end else begin
                divcnt <= divcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_pixel_streamer.sv
// Streams full frames from a combinational screen module to an SSD1331
// panel. Each frame is a 6-byte address-window burst followed by
// WIDTH*HEIGHT RGB565 pixels (high byte first), then a one-bit-time gap
// with cs_n released. enable is only looked at on frame boundaries.
// Ports: clk, rst_n; enable; oled_data (pixel at x/y); x, y (scan
// position); frame_begin, busy (status); cs_n, sclk, sdin, d_cn (SPI).
module oled_pixel_streamer
    import oled_pixel_streamer_pkg::*;
#(
    parameter int WIDTH   = OLED_WIDTH,
    parameter int HEIGHT  = OLED_HEIGHT,
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] oled_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        frame_begin,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic        sdin,
    output logic        d_cn
);
    localparam int NPIX = WIDTH * HEIGHT;
    // one counter serves as command index, pixel count and gap timer
    localparam int CWA  = ($clog2(NPIX + 1) > 3) ? $clog2(NPIX + 1) : 3;
    localparam int CW   = (CWA > $clog2(2 * CLK_DIV)) ? CWA : $clog2(2 * CLK_DIV);

    strm_state_e   st, st_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    pix_lo;   // high byte goes straight from oled_data to the serialiser
    logic          lo_pend;  // low byte of the captured pixel still to send

    logic          tx_load, tx_dc, tx_done;
    logic [7:0]    tx_byte;
    logic          start, cap;

    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_load),
        .data  (tx_byte),
        .dc_in (tx_dc),
        .sclk  (sclk),
        .sdin  (sdin),
        .d_cn  (d_cn),
        .done  (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        tx_load = 1'b0;
        tx_byte = 8'h00;
        tx_dc   = 1'b0;
        start   = 1'b0;
        cap     = 1'b0;
        unique case (st)
            IDLE: begin
                if (enable) begin
                    st_nxt  = CMD;
                    start   = 1'b1;
                    tx_load = 1'b1;
                    tx_byte = win_cmd_byte(3'd0, WIDTH, HEIGHT);
                end
            end
            CMD: begin
                if (tx_done) begin
                    tx_load = 1'b1;
                    if (cnt == CW'(6)) begin
                        st_nxt  = PIX;
                        cap     = 1'b1;
                        tx_byte = oled_data[15:8];
                        tx_dc   = 1'b1;
                    end else begin
                        tx_byte = win_cmd_byte(cnt[2:0], WIDTH, HEIGHT);
                    end
                end
            end
            PIX: begin
                if (tx_done) begin
                    if (lo_pend) begin
                        tx_load = 1'b1;
                        tx_byte = pix_lo;
                        tx_dc   = 1'b1;
                    end else if (cnt == CW'(NPIX)) begin
                        st_nxt = GAP;
                    end else begin
                        tx_load = 1'b1;
                        cap     = 1'b1;
                        tx_byte = oled_data[15:8];
                        tx_dc   = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == CW'(2 * CLK_DIV - 1)) begin
                    if (enable) begin
                        st_nxt  = CMD;
                        start   = 1'b1;
                        tx_load = 1'b1;
                        tx_byte = win_cmd_byte(3'd0, WIDTH, HEIGHT);
                    end else begin
                        st_nxt = IDLE;
                    end
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pix_lo      <= '0;
            lo_pend     <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_begin <= 1'b0;
            busy        <= 1'b0;
            cs_n        <= 1'b1;
        end else begin
            frame_begin <= start;
            busy        <= (st_nxt != IDLE);
            cs_n        <= !(st_nxt == CMD || st_nxt == PIX);
            if (start) begin
                cnt     <= CW'(1);
                lo_pend <= 1'b0;
                x       <= '0;
                y       <= '0;
            end else if (cap) begin
                // x/y move on as soon as the pixel is latched, giving the
                // screen module two byte-times to settle on the next one
                cnt     <= (st == CMD) ? CW'(1) : cnt + CW'(1);
                pix_lo  <= oled_data[7:0];
                lo_pend <= 1'b1;
                if (x == 7'(WIDTH - 1)) begin
                    x <= '0;
                    y <= (y == 6'(HEIGHT - 1)) ? 6'd0 : y + 6'd1;
                end else begin
                    x <= x + 7'd1;
                end
            end else if (tx_load) begin
                if (st == CMD) cnt <= cnt + CW'(1);
                lo_pend <= 1'b0;
            end else if (st == PIX && st_nxt == GAP) begin
                cnt <= '0;
            end else if (st == GAP) begin
                cnt <= (st_nxt == GAP) ? cnt + CW'(1) : '0;
            end
        end
    end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench: a 5x3 panel driven by two streamers (CLK_DIV=2 and CLK_DIV=1).
// A per-DUT monitor decodes the SPI bytes and records frame timing; the
// initial block compares them against hand-derived values.
module tb_oled_pixel_streamer;
    localparam int W = 5, H = 3, NPIX = W * H, NBYTES = 6 + 2 * NPIX;

    logic       clk = 1'b0, rst_n = 1'b0, mode = 1'b0;
    logic [1:0] en = 2'b00;
    logic [15:0] od0, od1;
    wire  [1:0][6:0] xs;
    wire  [1:0][5:0] ys;
    wire  [1:0] fb, busy, csn, sclk, sdin, dcn;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // screen model: either a constant colour or {y,x} as the pixel value
    assign od0 = mode ? 16'h5FFF : {3'b000, ys[0], xs[0]};
    assign od1 = mode ? 16'h5FFF : {3'b000, ys[1], xs[1]};

    oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .oled_data(od0),
        .x(xs[0]), .y(ys[0]), .frame_begin(fb[0]), .busy(busy[0]),
        .cs_n(csn[0]), .sclk(sclk[0]), .sdin(sdin[0]), .d_cn(dcn[0]));

    oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .oled_data(od1),
        .x(xs[1]), .y(ys[1]), .frame_begin(fb[1]), .busy(busy[1]),
        .cs_n(csn[1]), .sclk(sclk[1]), .sdin(sdin[1]), .d_cn(dcn[1]));

    function automatic int cdv(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int flen_exp(input int d);
        return NBYTES * 8 * 2 * cdv(d);
    endfunction

    function automatic int outs(input int d);
        return {13'd0, xs[d], ys[d], fb[d], busy[d], csn[d], sclk[d], sdin[d], dcn[d]};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int off[2], fbcnt[2], nb[2], nbit[2], adv[2], advbad[2], bitbad[2], lastfall[2];
    int period[2], flen[2], bfall[2], done_nb[2], done_adv[2], done_advbad[2], done_bitbad[2];
    logic [7:0]  sh[2];
    logic [8:0]  bytes[2][64], dbytes[2][64];
    logic [1:0]  p_sclk = 2'b11, p_csn = 2'b11, p_busy = 2'b00;
    logic [12:0] p_xy[2];

    initial for (int d = 0; d < 2; d++) begin
        off[d] = 0; fbcnt[d] = 0; nb[d] = 0; nbit[d] = 0; adv[d] = 0; advbad[d] = 0;
        bitbad[d] = 0; lastfall[d] = 0; period[d] = 0; flen[d] = 0; bfall[d] = 0;
        done_nb[d] = 0; done_adv[d] = 0; done_advbad[d] = 0; done_bitbad[d] = 0;
        sh[d] = 8'h00; p_xy[d] = 13'd0;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                off[d] = 0; nb[d] = 0; nbit[d] = 0; adv[d] = 0; advbad[d] = 0; bitbad[d] = 0;
            end else begin
                off[d]++;
                if (fb[d]) begin
                    period[d] = off[d];
                    off[d] = 0; nb[d] = 0; nbit[d] = 0; adv[d] = 0; advbad[d] = 0; bitbad[d] = 0;
                    fbcnt[d]++;
                end
                if (p_sclk[d] && !sclk[d] && !csn[d]) begin
                    if (nbit[d] > 0 && off[d] - lastfall[d] != 2 * cdv(d)) bitbad[d]++;
                    lastfall[d] = off[d];
                end
                if (!p_sclk[d] && sclk[d] && !csn[d]) begin
                    sh[d] = {sh[d][6:0], sdin[d]};
                    nbit[d]++;
                    if (nbit[d] % 8 == 0) begin
                        if (nb[d] < 64) bytes[d][nb[d]] = {dcn[d], sh[d]};
                        nb[d]++;
                    end
                end
                if (busy[d] && {ys[d], xs[d]} != p_xy[d]) begin
                    if (off[d] != (6 + 2 * adv[d]) * 16 * cdv(d)) advbad[d]++;
                    adv[d]++;
                end
                if (!p_csn[d] && csn[d]) begin
                    flen[d] = off[d];
                    done_nb[d] = nb[d]; done_adv[d] = adv[d];
                    done_advbad[d] = advbad[d]; done_bitbad[d] = bitbad[d];
                    for (int i = 0; i < 64; i++) dbytes[d][i] = bytes[d][i];
                end
                if (p_busy[d] && !busy[d]) bfall[d] = off[d];
            end
            p_xy[d] = {ys[d], xs[d]};
        end
        p_sclk = sclk; p_csn = csn; p_busy = busy;
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int         idx;   // byte position in the frame
        logic [8:0] exp;   // {d_cn, byte}
    } vec_t;
    vec_t tv[12];

    initial begin
        int n, bad, snap0, snap1;
        logic [15:0] v;

        tv[0]  = '{0,  9'h015}; tv[1]  = '{1,  9'h000}; tv[2]  = '{2,  9'h004};
        tv[3]  = '{3,  9'h075}; tv[4]  = '{4,  9'h000}; tv[5]  = '{5,  9'h002};
        tv[6]  = '{6,  9'h100}; tv[7]  = '{7,  9'h100}; tv[8]  = '{9,  9'h101};
        tv[9]  = '{17, 9'h180}; tv[10] = '{34, 9'h101}; tv[11] = '{35, 9'h104};

        // reset state
        repeat (3) tick();
        chk("reset_outs_d2", outs(0), 32'h0000_000D);
        chk("reset_outs_d1", outs(1), 32'h0000_000D);
        rst_n = 1'b1;
        tick();

        // phase A: {y,x} pattern, enable held high across two frames
        en = 2'b11;
        n = 0;
        while (fbcnt[0] < 2 && n < 4000) begin tick(); n++; end
        chk("wait_two_frames", int'(n < 4000), 1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("nbytes_d%0d", d), done_nb[d], NBYTES);
            foreach (tv[i])
                chk($sformatf("byte%0d_d%0d", tv[i].idx, d), dbytes[d][tv[i].idx], tv[i].exp);
            bad = 0;
            for (int k = 0; k < NPIX; k++) begin
                v = {3'b000, 6'(k / W), 7'(k % W)};
                if (dbytes[d][6 + 2 * k] != {1'b1, v[15:8]}) bad++;
                if (dbytes[d][7 + 2 * k] != {1'b1, v[7:0]}) bad++;
            end
            chk($sformatf("pixel_order_d%0d", d), bad, 0);
            chk($sformatf("frame_len_d%0d", d), flen[d], flen_exp(d));
            chk($sformatf("fb_period_d%0d", d), period[d], flen_exp(d) + 2 * cdv(d));
            chk($sformatf("xy_adv_count_d%0d", d), done_adv[d], NPIX);
            chk($sformatf("xy_adv_timing_d%0d", d), done_advbad[d], 0);
            chk($sformatf("bit_len_d%0d", d), done_bitbad[d], 0);
        end

        // enable dropped mid-frame: frame completes, then idle
        n = 0;
        while (adv[0] < 5 && n < 2000) begin tick(); n++; end
        chk("wait_mid_frame", int'(n < 2000), 1);
        en = 2'b00;
        snap0 = fbcnt[0]; snap1 = fbcnt[1];
        n = 0;
        while (busy != 2'b00 && n < 3000) begin tick(); n++; end
        chk("wait_idle_a", int'(n < 3000), 1);
        repeat (2500) tick();
        chk("no_refire_d2", fbcnt[0], snap0);
        chk("no_refire_d1", fbcnt[1], snap1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("drop_frame_len_d%0d", d), flen[d], flen_exp(d));
            chk($sformatf("busy_fall_d%0d", d), bfall[d], flen_exp(d) + 2 * cdv(d));
        end
        chk("idle_outs_d2", outs(0), 32'h0000_000D);

        // phase B: constant colour, single frame
        mode = 1'b1;
        snap0 = fbcnt[0]; snap1 = fbcnt[1];
        en = 2'b11;
        n = 0;
        while ((fbcnt[0] == snap0 || fbcnt[1] == snap1) && n < 100) begin tick(); n++; end
        chk("wait_fb_b", int'(n < 100), 1);
        en = 2'b00;
        n = 0;
        while (busy != 2'b00 && n < 3000) begin tick(); n++; end
        chk("wait_idle_b", int'(n < 3000), 1);
        for (int d = 0; d < 2; d++) begin
            bad = 0;
            for (int i = 6; i < NBYTES; i++)
                if (dbytes[d][i] != ((i % 2 == 0) ? 9'h15F : 9'h1FF)) bad++;
            chk($sformatf("colour_bytes_d%0d", d), bad, 0);
            chk($sformatf("colour_nbytes_d%0d", d), done_nb[d], NBYTES);
            chk($sformatf("colour_len_d%0d", d), flen[d], flen_exp(d));
        end

        // phase C: async reset in the middle of the pixel phase
        mode = 1'b0;
        en = 2'b01;
        n = 0;
        while (!(busy[0] && off[0] >= 300) && n < 1000) begin tick(); n++; end
        chk("wait_mid_pix", int'(n < 1000), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs_d2", outs(0), 32'h0000_000D);
        tick();
        rst_n = 1'b1;
        chk("release_no_fb", int'(fb[0]), 0);
        tick();
        chk("restart_fb", int'(fb[0]), 1);
        chk("restart_busy", int'(busy[0]), 1);
        en = 2'b00;
        n = 0;
        while (busy != 2'b00 && n < 3000) begin tick(); n++; end
        chk("wait_idle_c", int'(n < 3000), 1);
        chk("restart_frame_len", flen[0], flen_exp(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
